// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter with LUT-relative branches and an IDLE/RUN/HALT sequencer
// Ports: clk, reset (async, active-high); start, branch, how_high, take, halt_req, stall (sequencing inputs);
// lut_we, lut_idx, lut_data (offset table write port); prog_ctr, running, done, cycles (registered outputs)
module fetch_pc_unit #(
  parameter int PCW = 10,
  parameter int LUTN = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            branch,
  input  logic [1:0]      how_high,
  input  logic            take,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            lut_we,
  input  logic [1:0]      lut_idx,
  input  logic [PCW-1:0]  lut_data,
  output logic [PCW-1:0]  prog_ctr,
  output logic            running,
  output logic            done,
  output logic [CNTW-1:0] cycles
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state;
  logic [PCW-1:0] lut [LUTN];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prog_ctr <= '0;
      cycles <= '0;
      running <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < LUTN; i++) lut[i] <= '0;
    end else begin
      if (lut_we) lut[lut_idx] <= lut_data;
      if (state != RUN) begin
        if (start) begin
          state <= RUN;
          running <= 1'b1;
          done <= 1'b0;
          prog_ctr <= '0;
          cycles <= '0;
        end
      end else if (!stall) begin
        cycles <= &cycles ? cycles : cycles + 1'b1;
        if (halt_req) begin
          state <= HALT;
          running <= 1'b0;
          done <= 1'b1;
        end else begin
          // lut read sees the pre-write value, so a same-cycle write lands next cycle
          prog_ctr <= (branch && take) ? prog_ctr + lut[how_high] : prog_ctr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;
  logic clk = 0, reset = 1, start = 0, branch = 0, take = 0, halt_req = 0, stall = 0, lut_we = 0;
  logic [1:0] how_high = 0, lut_idx = 0;
  logic [9:0] lut_data = 0, prog_ctr;
  logic running, done;
  logic [3:0] cycles;
  int errors = 0, checks = 0;

  typedef struct {
    logic s, b; logic [1:0] h; logic t, hq, st, w; logic [1:0] i; logic [9:0] d;
    logic [9:0] pc; logic run, dn; logic [3:0] cyc;
  } vec_t;
  typedef struct { logic [9:0] pc; logic run, dn; logic [3:0] cyc; } exp_t;
  vec_t v[$];
  exp_t sb[$];

  fetch_pc_unit #(.PCW(10), .LUTN(4), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .branch(branch), .how_high(how_high), .take(take),
    .halt_req(halt_req), .stall(stall), .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data),
    .prog_ctr(prog_ctr), .running(running), .done(done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int s, int b, int h, int t, int hq, int st, int w, int i, int d,
                              int pc, int run, int dn, int cyc);
    vec_t r;
    r.s = s[0]; r.b = b[0]; r.h = 2'(h); r.t = t[0]; r.hq = hq[0]; r.st = st[0]; r.w = w[0];
    r.i = 2'(i); r.d = 10'(d); r.pc = 10'(pc); r.run = run[0]; r.dn = dn[0]; r.cyc = 4'(cyc);
    return r;
  endfunction

  task automatic expect_out(input logic [9:0] pc, input logic run, input logic dn, input logic [3:0] cyc);
    exp_t e;
    e.pc = pc; e.run = run; e.dn = dn; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (prog_ctr !== e.pc || running !== e.run || done !== e.dn || cycles !== e.cyc) begin
      errors++;
      $display("FAIL %s: got pc=%0d run=%b done=%b cyc=%0d, want pc=%0d run=%b done=%b cyc=%0d",
               name, prog_ctr, running, done, cycles, e.pc, e.run, e.dn, e.cyc);
    end
  endtask

  task automatic apply(input vec_t r, input string name);
    start = r.s; branch = r.b; how_high = r.h; take = r.t; halt_req = r.hq; stall = r.st;
    lut_we = r.w; lut_idx = r.i; lut_data = r.d;
    expect_out(r.pc, r.run, r.dn, r.cyc);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    //                   s b h t hq st w i d      pc  run dn cyc
    v.push_back(mk(0,0,0,0,0,0, 1,2,7,     0,   0,0,0));
    v.push_back(mk(0,0,0,0,0,0, 1,1,1021,  0,   0,0,0));
    v.push_back(mk(0,1,2,1,0,0, 0,0,0,     0,   0,0,0));
    v.push_back(mk(1,0,0,0,0,0, 0,0,0,     0,   1,0,0));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     1,   1,0,1));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     2,   1,0,2));
    v.push_back(mk(1,0,0,0,0,0, 0,0,0,     3,   1,0,3));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     4,   1,0,4));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     5,   1,0,5));
    v.push_back(mk(0,1,1,1,0,0, 0,0,0,     2,   1,0,6));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     3,   1,0,7));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     4,   1,0,8));
    v.push_back(mk(0,1,2,1,0,0, 0,0,0,     11,  1,0,9));
    v.push_back(mk(0,1,1,1,0,0, 0,0,0,     8,   1,0,10));
    v.push_back(mk(0,1,1,0,0,0, 0,0,0,     9,   1,0,11));
    for (int k = 0; k < 3; k++) v.push_back(mk(0,1,2,1,1,1, 0,0,0, 9, 1,0,11));
    v.push_back(mk(0,1,2,1,0,0, 1,3,1017,  16,  1,0,12));
    v.push_back(mk(0,1,3,1,0,0, 0,0,0,     9,   1,0,13));
    v.push_back(mk(0,0,0,0,1,0, 0,0,0,     9,   0,1,14));
    for (int k = 0; k < 10; k++) v.push_back(mk(0,k%2,k%4,1,k%3==0,0, 0,0,0, 9, 0,1,14));
    v.push_back(mk(1,0,0,0,0,0, 1,2,510,   0,   1,0,0));
    v.push_back(mk(0,1,2,1,0,0, 0,0,0,     510, 1,0,1));
    v.push_back(mk(0,1,2,1,0,0, 1,0,6,     1020,1,0,2));
    v.push_back(mk(0,1,0,1,0,0, 0,0,0,     2,   1,0,3));
    v.push_back(mk(0,1,1,1,0,0, 1,1,1022,  1023,1,0,4));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     0,   1,0,5));
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,     1,   1,0,6));
    v.push_back(mk(0,1,1,1,0,0, 0,0,0,     1023,1,0,7));
    v.push_back(mk(0,0,0,0,0,0, 1,0,2,     0,   1,0,8));
    v.push_back(mk(0,1,0,1,0,0, 1,0,5,     2,   1,0,9));
    v.push_back(mk(0,1,0,1,0,0, 0,0,0,     7,   1,0,10));
    v.push_back(mk(0,0,0,0,0,0, 1,3,0,     8,   1,0,11));
    v.push_back(mk(0,1,3,1,0,0, 0,0,0,     8,   1,0,12));
    for (int k = 0; k < 8; k++) v.push_back(mk(0,0,0,0,0,0, 0,0,0, 9+k, 1,0,(13+k > 15) ? 15 : 13+k));

    repeat (2) @(posedge clk);
    #1 reset = 0;
    expect_out(0, 0, 0, 0);
    check("reset_state");
    foreach (v[n]) apply(v[n], $sformatf("vec%0d", n));

    // asynchronous reset mid-RUN, observed without a clock edge
    #2 reset = 1;
    #1;
    expect_out(0, 0, 0, 0);
    check("async_reset");
    start = 1;
    @(posedge clk);
    #1;
    expect_out(0, 0, 0, 0);
    check("reset_holds");
    reset = 0;
    apply(mk(1,0,0,0,0,0, 0,0,0, 0, 1,0,0), "restart_after_reset");
    apply(mk(0,1,2,1,0,0, 0,0,0, 0, 1,0,1), "lut_cleared_h2");
    apply(mk(0,1,1,1,0,0, 0,0,0, 0, 1,0,2), "lut_cleared_h1");
    apply(mk(0,0,0,0,0,0, 0,0,0, 1, 1,0,3), "step_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
